uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (send_trigger/send_data/tx_busy interface) between
//  NUM_REQ byte requesters. Round-robin arbitration with per-requester message lock
//  (grant held until byte flagged last), so multi-byte strings such as "ALEX" go out
//  unbroken. Sequences trigger pulse, waits for transmitter busy/done, flags timeouts.
// PARAMETERS
//  NUM_REQ       4      number of requesters (2..8)
//  TRIG_CYCLES   40     clocks send_trigger held high per byte (>=1; 800 ns at 50 MHz)
//  BUSY_TIMEOUT  1000   clocks after trigger drop to wait for tx_busy before error
// PORTS
//  user_clock   in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  req_valid    in   NUM_REQ    requester i has byte pending; hold until req_ack[i]
//  req_data     in   8*NUM_REQ  byte of requester i at [8*i+:8]; stable while valid
//  req_last     in   NUM_REQ    byte of requester i ends its message (releases lock)
//  req_ack      out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//  grant        out  NUM_REQ    one-hot owner of the transmitter; 0 when idle/unlocked
//  tx_busy      in   1          transmitter shifting a frame
//  send_trigger out  1          transmit strobe to UART
//  send_data    out  8          byte to UART; held stable until next accept
//  arb_busy     out  1          1 in any state other than IDLE
//  err_timeout  out  1          one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; req_ack, grant, send_trigger, send_data,
//   arb_busy, err_timeout = 0; rr_ptr = 0; lock cleared; counters 0. Applies in any
//   state: trigger drops the cycle after reset edge, no ack or error issued.
//  States: IDLE -> TRIG -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: candidates = req_valid, masked to locked owner only when lock set.
//   Winner w = first set candidate searching rr_ptr, rr_ptr+1, .. modulo NUM_REQ.
//   On edge with winner: send_data<=req_data[w], send_trigger<=1, req_ack[w]<=1 for
//   one cycle, grant<=onehot(w), rr_ptr<=(w+1) mod NUM_REQ, lock<=~req_last[w],
//   busy_seen<=0, go TRIG. Accept-to-trigger latency: 1 clock. No candidates: stay.
//  TRIG: send_trigger high exactly TRIG_CYCLES clocks total; tx_busy=1 at any edge
//   sets busy_seen. After last cycle: send_trigger<=0, counter<=0, go WAIT_BUSY.
//  WAIT_BUSY: tx_busy=1 or busy_seen -> WAIT_DONE. Else counter increments; when it
//   reaches BUSY_TIMEOUT-1 without busy: err_timeout pulse, lock cleared, grant<=0,
//   go IDLE (byte is dropped, not retried).
//  WAIT_DONE: tx_busy=0 at edge -> IDLE; grant<=0 unless lock set (grant kept).
//  Lock: while set, other requesters' valid ignored (they wait, no ack); released on
//   accepting a byte with req_last=1, on timeout, or reset. No lock timeout exists.
//  req_ack never asserts for a requester whose req_valid was 0 at the accept edge;
//   at most one req_ack bit high per cycle; next accept no sooner than 1 cycle after
//   WAIT_DONE exit (min byte period TRIG_CYCLES+3 clocks).
//  req_valid dropped before ack: no effect outside IDLE; in IDLE simply not a candidate.
//  Counters sized $clog2 of their max; no wrap occurs within a state.
// TESTING
//  1 Reset: rst high 3 clocks mid-TRIG -> send_trigger 0 next cycle, all outputs 0,
//    next accept starts from requester 0.
//  2 Single byte: req_valid=4'b0001, data 8'h41, last=1, model UART busy 10 clocks ->
//    ack[0] one pulse, send_trigger high 40 clocks, send_data=8'h41, back to IDLE.
//  3 Round robin: all 4 valid, last=1 each, bytes 8'h10..8'h13 -> sends in order
//    0,1,2,3 then repeat from 0; each ack exactly once per byte.
//  4 Lock: req 2 sends "ALEX" (last only on 'X') while req 0 valid -> 41,4C,45,58
//    contiguous, grant=4'b0100 throughout, req 0 byte sent afterwards.
//  5 Timeout: UART model never asserts busy -> err_timeout pulse exactly
//    TRIG_CYCLES+BUSY_TIMEOUT clocks after trigger rise, lock cleared, IDLE.
//  6 Early busy: tx_busy pulses high and low entirely within TRIG -> no timeout, one
//    byte completes, arbiter returns IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the UART transmit arbiter, its byte requesters and the shared UART.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_busy;
    logic                 send_trigger;
    logic [7:0]           send_data;
    logic                 arb_busy;
    logic                 err_timeout;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ack, grant, send_trigger, send_data, arb_busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ack, grant, send_trigger, send_data, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters,
// holding the grant across multi-byte messages until the byte flagged last.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TRIG_CYCLES  = 40,
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic              user_clock,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TRIG_CYCLES > BUSY_TIMEOUT) ? TRIG_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_BUSY, WAIT_DONE} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic               lock_q, lock_d;
    logic               busy_seen_q, busy_seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               trig_q, trig_d;
    logic [7:0]         data_q, data_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     pos;
    logic [PTR_W:0]     rr_next;
    logic [NUM_REQ-1:0] win_onehot;

    // While locked the owner is the only candidate; its identity is the held grant.
    always_comb begin
        cand      = lock_q ? (bus.req_valid & grant_q) : bus.req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && cand[pos[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[PTR_W-1:0];
            end
        end
        rr_next = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (rr_next >= (PTR_W+1)'(NUM_REQ)) begin
            rr_next = '0;
        end
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        lock_d      = lock_q;
        busy_seen_d = busy_seen_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        grant_d     = grant_q;
        trig_d      = trig_q;
        data_d      = data_q;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    data_d      = bus.req_data[{win_idx, 3'b000} +: 8];
                    trig_d      = 1'b1;
                    ack_d       = win_onehot;
                    grant_d     = win_onehot;
                    rr_d        = rr_next[PTR_W-1:0];
                    lock_d      = ~bus.req_last[win_idx];
                    busy_seen_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = TRIG;
                end
            end
            TRIG: begin
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end
                if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy || busy_seen_q) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Byte is dropped; the message lock must not outlive a dead transmitter.
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clock) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            busy_seen_q <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= '0;
            grant_q     <= '0;
            trig_q      <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            busy_seen_q <= busy_seen_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            grant_q     <= grant_d;
            trig_q      <= trig_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.grant        = grant_q;
    assign bus.send_trigger = trig_q;
    assign bus.send_data    = data_q;
    assign bus.arb_busy     = (state_q != IDLE);
    assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed bytes, a scoreboard holds the
// expected (requester, byte) order, and a simple UART model answers each trigger.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TRIG = 40;
    localparam int BTO  = 1000;

    typedef struct {
        int       id;
        bit [7:0] data;
    } exp_t;

    logic user_clock;
    logic rst;
    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(NREQ), .TRIG_CYCLES(TRIG), .BUSY_TIMEOUT(BTO)
    ) dut (
        .user_clock(user_clock),
        .rst       (rst),
        .bus       (bus)
    );

    int       checks;
    int       failures;
    int       cyc;
    int       err_count;
    int       uart_mode;   // 0 normal, 1 never busy, 2 busy pulse inside trigger
    int       ucnt;
    int       edly;
    exp_t     sb[$];
    bit [8:0] rq[NREQ][$];

    initial begin
        user_clock = 1'b0;
        forever #5 user_clock = ~user_clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic enq(input int id, input bit [7:0] d, input bit last);
        rq[id].push_back({last, d});
    endtask

    task automatic expect_byte(input int id, input bit [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic bit rq_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge user_clock);
            n++;
        end while (!(sb.size() == 0 && rq_empty() && !bus.arb_busy && !bus.tx_busy &&
                     ucnt == 0 && edly == 0) && n < budget);
        check(tag, 32'(n < budget), 32'd1);
    endtask

    // Monitor, requester driver and UART model share one negedge process.
    initial begin
        logic prev_trig;
        logic prev_err;
        int   trig_len;
        int   rise_cyc;
        int   id;
        bit   trig_abort;
        exp_t e;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        prev_trig = 1'b0;
        prev_err  = 1'b0;
        trig_len  = 0;
        rise_cyc  = 0;
        trig_abort = 1'b0;
        forever begin
            @(negedge user_clock);
            cyc++;
            if (bus.req_ack !== '0) begin
                check("ack_onehot", 32'($onehot(bus.req_ack)), 32'd1);
                check("ack_without_valid", 32'(bus.req_ack & ~bus.req_valid), 32'd0);
                id = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) id = i;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(bus.req_ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_id", 32'(id), 32'(e.id));
                    check("send_data", 32'(bus.send_data), 32'(e.data));
                    check("grant_at_ack", 32'(bus.grant), 32'(4'b0001 << e.id));
                end
                if (rq[id].size() > 0) void'(rq[id].pop_front());
            end
            if (!prev_trig && bus.send_trigger) begin
                trig_abort = 1'b0;
                trig_len   = 0;
                rise_cyc   = cyc;
            end
            if (rst) trig_abort = 1'b1;
            if (bus.send_trigger) trig_len++;
            if (prev_trig && !bus.send_trigger && !trig_abort) begin
                check("trigger_len", 32'(trig_len), 32'(TRIG));
            end
            if (bus.err_timeout) begin
                err_count++;
                check("timeout_latency", 32'(cyc - rise_cyc), 32'(TRIG + BTO));
                check("err_pulse_width", 32'(prev_err), 32'd0);
            end
            if (uart_mode == 0 && prev_trig && !bus.send_trigger) begin
                bus.tx_busy = 1'b1;
                ucnt = 10;
            end else if (uart_mode == 2 && !prev_trig && bus.send_trigger) begin
                edly = 5;
            end else if (edly > 0) begin
                edly--;
                if (edly == 0) begin
                    bus.tx_busy = 1'b1;
                    ucnt = 3;
                end
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) bus.tx_busy = 1'b0;
            end
            prev_trig = bus.send_trigger;
            prev_err  = bus.err_timeout;
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = (rq[i].size() > 0);
                bus.req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
                bus.req_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
            end
        end
    end

    initial begin
        int  n;
        int  bad;
        bit  added;
        checks = 0; failures = 0; cyc = 0; err_count = 0;
        uart_mode = 0; ucnt = 0; edly = 0;
        rst = 1'b1;
        repeat (3) @(negedge user_clock);
        check("rst_trigger", 32'(bus.send_trigger), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a trigger
        enq(2, 8'h77, 1'b1);
        expect_byte(2, 8'h77);
        n = 0;
        while (!bus.send_trigger && n < 50) begin
            @(negedge user_clock);
            n++;
        end
        check("first_trigger_seen", 32'(n < 50), 32'd1);
        repeat (10) @(negedge user_clock);
        rst = 1'b1;
        @(negedge user_clock);
        check("midrst_trigger", 32'(bus.send_trigger), 32'd0);
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_ack", 32'(bus.req_ack), 32'd0);
        check("midrst_arb_busy", 32'(bus.arb_busy), 32'd0);
        check("midrst_err", 32'(bus.err_timeout), 32'd0);
        check("midrst_send_data", 32'(bus.send_data), 32'd0);
        repeat (2) @(negedge user_clock);
        rst = 1'b0;
        repeat (20) @(negedge user_clock);
        enq(3, 8'h33, 1'b1);
        enq(0, 8'h30, 1'b1);
        expect_byte(0, 8'h30);
        expect_byte(3, 8'h33);
        wait_idle("after_reset_order", 1000);

        // Round robin over all four requesters, two bytes each
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                enq(i, 8'(8'h10 + i), 1'b1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                expect_byte(i, 8'(8'h10 + i));
            end
        end
        wait_idle("round_robin_done", 3000);

        // Single byte
        enq(0, 8'h41, 1'b1);
        expect_byte(0, 8'h41);
        wait_idle("single_done", 500);
        check("send_data_held", 32'(bus.send_data), 32'h41);
        check("single_grant_released", 32'(bus.grant), 32'd0);

        // Locked message "ALEX" from requester 2 while requester 0 waits
        enq(2, 8'h41, 1'b0);
        enq(2, 8'h4C, 1'b0);
        enq(2, 8'h45, 1'b0);
        enq(2, 8'h58, 1'b1);
        expect_byte(2, 8'h41);
        expect_byte(2, 8'h4C);
        expect_byte(2, 8'h45);
        expect_byte(2, 8'h58);
        expect_byte(0, 8'h30);
        added = 1'b0;
        bad = 0;
        n = 0;
        while (!(rq[2].size() == 0 && !bus.arb_busy) && n < 2000) begin
            @(negedge user_clock);
            n++;
            if (!added && rq[2].size() == 3) begin
                enq(0, 8'h30, 1'b1);
                added = 1'b1;
            end
            if (rq[2].size() < 4 && (rq[2].size() > 0 || bus.arb_busy) && bus.grant !== 4'b0100) bad++;
        end
        check("lock_window_done", 32'(n < 2000), 32'd1);
        check("lock_grant_held", 32'(bad), 32'd0);
        wait_idle("lock_done", 1000);

        // Transmitter never responds
        uart_mode = 1;
        enq(1, 8'h55, 1'b0);
        expect_byte(1, 8'h55);
        n = 0;
        while (err_count == 0 && n < 1500) begin
            @(negedge user_clock);
            n++;
        end
        check("timeout_seen", 32'(err_count), 32'd1);
        uart_mode = 0;
        @(negedge user_clock);
        check("timeout_idle", 32'(bus.arb_busy), 32'd0);
        check("timeout_grant", 32'(bus.grant), 32'd0);
        enq(3, 8'h66, 1'b1);
        expect_byte(3, 8'h66);
        wait_idle("after_timeout", 500);

        // Busy pulse entirely inside the trigger window
        uart_mode = 2;
        enq(1, 8'h5A, 1'b1);
        expect_byte(1, 8'h5A);
        wait_idle("early_busy_done", 500);
        check("early_busy_no_err", 32'(err_count), 32'd1);
        check("early_busy_idle", 32'(bus.arb_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
